// File: rtl/mcpu_mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter for the single-port MCPU RAM with registered port drive and read-latency timing.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise the CPU has fixed priority.
module mcpu_mem_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_done,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0]  dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_done,
    output logic [WORD_SIZE-1:0]  dma_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    input  logic [WORD_SIZE-1:0]  ram_rdata
);

    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t          state_r;
    logic            owner_r;      // 1 = DMA owns the current access
    logic [CW-1:0]   cnt_r;
    logic            any_req_s;
    logic            grant_dma_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic            last_dma_r;
`endif

    // Winner selection among the pending requests
    always_comb begin
        any_req_s   = cpu_req | dma_req;
        grant_dma_s = 1'b0;
        if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_dma_s = ~last_dma_r;
`else
            grant_dma_s = 1'b0;
`endif
        end else if (dma_req) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_dma_s = 1'b0;
        end
    end

    // Access sequencer: IDLE -> ACCESS -> (WAIT) -> IDLE, all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            owner_r   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            cpu_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            cpu_rdata <= {WORD_SIZE{1'b0}};
            dma_gnt   <= 1'b0;
            dma_done  <= 1'b0;
            dma_rdata <= {WORD_SIZE{1'b0}};
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= {ADDR_WIDTH{1'b0}};
            ram_wdata <= {WORD_SIZE{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_r <= 1'b1;
`endif
        end else begin
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        owner_r   <= grant_dma_s;
                        ram_en    <= 1'b1;
                        ram_we    <= grant_dma_s ? dma_we    : cpu_we;
                        ram_addr  <= grant_dma_s ? dma_addr  : cpu_addr;
                        ram_wdata <= grant_dma_s ? dma_wdata : cpu_wdata;
                        cpu_gnt   <= ~grant_dma_s;
                        dma_gnt   <= grant_dma_s;
                        state_r   <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dma_r <= grant_dma_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        cpu_done <= ~owner_r;
                        dma_done <= owner_r;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r   <= CW'(RAM_LATENCY - 1);
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter reaching zero marks the cycle ram_rdata is valid
                    if (cnt_r == {CW{1'b0}}) begin
                        if (owner_r) begin
                            dma_rdata <= ram_rdata;
                        end else begin
                            cpu_rdata <= ram_rdata;
                        end
                        cpu_done <= ~owner_r;
                        dma_done <= owner_r;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    ram_en  <= 1'b0;
                    ram_we  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Bench for mcpu_mem_arbiter: two instances (RAM latency 1 and 3), transaction-level model checked every cycle,
// plus directed latency/data checks.
module tb_mcpu_mem_arbiter;

    logic clk;
    logic reset;
    logic [1:0]       cpu_req, cpu_we, dma_req, dma_we;
    logic [1:0]       cpu_gnt, cpu_done, dma_gnt, dma_done, ram_en, ram_we;
    logic [1:0][7:0]  cpu_addr, dma_addr, ram_addr;
    logic [1:0][15:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cgc   = 0;

    mcpu_mem_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(8), .RAM_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_gnt(cpu_gnt[0]), .cpu_done(cpu_done[0]), .cpu_rdata(cpu_rdata[0]),
        .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
        .dma_gnt(dma_gnt[0]), .dma_done(dma_done[0]), .dma_rdata(dma_rdata[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_rdata(ram_rdata[0])
    );

    mcpu_mem_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(8), .RAM_LATENCY(3)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_gnt(cpu_gnt[1]), .cpu_done(cpu_done[1]), .cpu_rdata(cpu_rdata[1]),
        .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
        .dma_gnt(dma_gnt[1]), .dma_done(dma_done[1]), .dma_rdata(dma_rdata[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_rdata(ram_rdata[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Synchronous RAMs with 1-cycle and 3-cycle read latency
    logic [15:0] bmem [2][256];
    logic [15:0] pipe [2][3];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_en[i] && ram_we[i]) bmem[i][ram_addr[i]] <= ram_wdata[i];
            if (ram_en[i] && !ram_we[i]) pipe[i][0] <= bmem[i][ram_addr[i]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end
    assign ram_rdata[0] = pipe[0][0];
    assign ram_rdata[1] = pipe[1][2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Transaction model: per instance, when the next grant may happen and what each grant produces
    int          lat [2] = '{1, 3};
    int          m_next [2] = '{0, 0};
    int          m_gnt  [2] = '{-1, -1};
    int          m_done [2] = '{-1, -1};
    bit          m_dma  [2];
    bit          m_we   [2];
    bit          m_last_dma [2] = '{1'b1, 1'b1};
    logic [7:0]  m_addr [2];
    logic [15:0] m_wdata[2];
    logic [15:0] m_pend [2];
    logic [15:0] m_crd  [2] = '{16'h0, 16'h0};
    logic [15:0] m_drd  [2] = '{16'h0, 16'h0};
    logic [15:0] mmem   [2][256];

    task automatic model_step(input int i);
        bit w;
        if (!reset) begin
            m_next[i] = 0; m_gnt[i] = -1; m_done[i] = -1;
            m_crd[i] = 16'h0; m_drd[i] = 16'h0; m_last_dma[i] = 1'b1;
        end else begin
            if (cyc == m_done[i] && !m_we[i]) begin
                if (m_dma[i]) m_drd[i] = m_pend[i];
                else          m_crd[i] = m_pend[i];
            end
            if (cyc >= m_next[i] && (cpu_req[i] || dma_req[i])) begin
                if (cpu_req[i] && dma_req[i]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = !m_last_dma[i];
`else
                    w = 1'b0;
`endif
                end else begin
                    w = dma_req[i];
                end
                m_dma[i]   = w;
                m_we[i]    = w ? dma_we[i]    : cpu_we[i];
                m_addr[i]  = w ? dma_addr[i]  : cpu_addr[i];
                m_wdata[i] = w ? dma_wdata[i] : cpu_wdata[i];
                m_gnt[i]   = cyc;
                m_last_dma[i] = w;
                if (m_we[i]) begin
                    m_done[i] = cyc + 1;
                    m_next[i] = cyc + 2;
                    mmem[i][m_addr[i]] = m_wdata[i];
                end else begin
                    m_done[i] = cyc + 1 + lat[i];
                    m_next[i] = cyc + 2 + lat[i];
                    m_pend[i] = mmem[i][m_addr[i]];
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0);
            model_step(1);
        end
    end

    // Per-cycle comparison of both DUTs against the model, at the falling edge
    initial begin
        logic eg, ed;
        forever begin
            @(negedge clk);
            if (cpu_gnt[0]) cgc++;
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    chk($sformatf("rst_ctl%0d", i),
                        {26'd0, cpu_gnt[i], dma_gnt[i], cpu_done[i], dma_done[i], ram_en[i], ram_we[i]}, 32'd0);
                    chk($sformatf("rst_rdata%0d", i), {cpu_rdata[i], dma_rdata[i]}, 32'd0);
                end else begin
                    eg = (cyc == m_gnt[i]);
                    ed = (cyc == m_done[i]);
                    chk($sformatf("ctl%0d", i),
                        {26'd0, cpu_gnt[i], dma_gnt[i], cpu_done[i], dma_done[i], ram_en[i], ram_we[i]},
                        {26'd0, eg & !m_dma[i], eg & m_dma[i], ed & !m_dma[i], ed & m_dma[i], eg, eg & m_we[i]});
                    chk($sformatf("cpu_rdata%0d", i), {16'd0, cpu_rdata[i]}, {16'd0, m_crd[i]});
                    chk($sformatf("dma_rdata%0d", i), {16'd0, dma_rdata[i]}, {16'd0, m_drd[i]});
                    if (eg) chk($sformatf("ram_addr%0d", i), {24'd0, ram_addr[i]}, {24'd0, m_addr[i]});
                    if (eg && m_we[i]) chk($sformatf("ram_wdata%0d", i), {16'd0, ram_wdata[i]}, {16'd0, m_wdata[i]});
                end
            end
        end
    end

    // One complete access; latency is counted in cycles from the sampling edge to the done cycle
    task automatic do_access(input int inst, input bit dma, input bit we, input logic [7:0] addr,
                             input logic [15:0] wd, output int lat_obs, output logic [15:0] rd);
        int gs, ds;
        gs = -1; ds = -1; rd = 16'h0; lat_obs = -1;
        if (dma) begin
            dma_req[inst] = 1'b1; dma_we[inst] = we; dma_addr[inst] = addr; dma_wdata[inst] = wd;
        end else begin
            cpu_req[inst] = 1'b1; cpu_we[inst] = we; cpu_addr[inst] = addr; cpu_wdata[inst] = wd;
        end
        for (int k = 0; k < 30 && gs < 0; k++) begin
            @(negedge clk); #1;
            if (dma ? dma_gnt[inst] : cpu_gnt[inst]) gs = cyc;
        end
        dma_req[inst] = 1'b0;
        cpu_req[inst] = 1'b0;
        if (gs < 0) begin
            chk("gnt_timeout", 32'd0, 32'd1);
        end else begin
            for (int k = 0; k < 30 && ds < 0; k++) begin
                @(negedge clk); #1;
                if (dma ? dma_done[inst] : cpu_done[inst]) begin
                    ds = cyc;
                    rd = dma ? dma_rdata[inst] : cpu_rdata[inst];
                end
            end
            if (ds < 0) chk("done_timeout", 32'd0, 32'd1);
            else        lat_obs = ds - gs + 1;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (n) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int          l;
        int          c0;
        int          n, ncpu;
        bit          seq [8];
        logic [15:0] rd;

        reset = 1'b0;
        cpu_req = 2'b00; cpu_we = 2'b00; dma_req = 2'b00; dma_we = 2'b00;
        cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) mmem[i][a] = 16'h0;

        // 1: request held through reset is not granted until release
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h10; cpu_wdata[0] = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_gnt", {31'd0, cpu_gnt[0]}, 32'd0);
            chk("rst_ram_en", {31'd0, ram_en[0]}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        chk("gnt_after_release", {31'd0, cpu_gnt[0]}, 32'd1);
        cpu_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // 2: CPU write then read back, latency 1
        do_access(0, 1'b0, 1'b1, 8'd20, 16'h0008, l, rd);
        chk("wr_latency", l, 32'd2);
        do_access(0, 1'b0, 1'b0, 8'd20, 16'h0000, l, rd);
        chk("rd_latency", l, 32'd3);
        chk("rd_data20", {16'd0, rd}, 32'h0008);

        // 3: DMA loads a program, CPU reads word 5
        c0 = cgc;
        for (int k = 0; k < 24; k++) begin
            do_access(0, 1'b1, 1'b1, 8'(k), 16'hA000 | 16'(k), l, rd);
            if (k == 0) chk("dma_wr_latency", l, 32'd2);
        end
        chk("no_cpu_gnt_during_dma", cgc - c0, 32'd0);
        do_access(0, 1'b0, 1'b0, 8'd5, 16'h0000, l, rd);
        chk("rd_word5", {16'd0, rd}, 32'h0000A005);

        // 4: both requesters held for 8 accesses, starting from reset
        pulse_reset(2);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h40; cpu_wdata[0] = 16'h0C0C;
        dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 8'h41; dma_wdata[0] = 16'h0D0D;
        n = 0; ncpu = 0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            @(negedge clk); #1;
            if (cpu_gnt[0]) begin seq[n] = 1'b0; n++; ncpu++; end
            if (dma_gnt[0]) begin seq[n] = 1'b1; n++; end
            if (n == 8) begin cpu_req[0] = 1'b0; dma_req[0] = 1'b0; end
        end
        cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
        chk("arb_count", n, 32'd8);
`ifdef ARB_ROUND_ROBIN_EN
        chk("arb_cpu_gnts", ncpu, 32'd4);
        for (int k = 0; k < 8; k++) chk($sformatf("arb_seq%0d", k), {31'd0, seq[k]}, 32'(k % 2));
`else
        chk("arb_cpu_gnts", ncpu, 32'd8);
`endif
        repeat (3) @(negedge clk);
        #1;

        // 5: reset during the WAIT of a CPU read aborts it; the next read is clean
        do_access(0, 1'b0, 1'b1, 8'd30, 16'h5A5A, l, rd);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'd30;
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            @(negedge clk); #1;
            if (cpu_gnt[0]) n = 1;
        end
        cpu_req[0] = 1'b0;
        chk("abort_gnt_seen", n, 32'd1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_ram_en", {31'd0, ram_en[0]}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("abort_no_done", {31'd0, cpu_done[0]}, 32'd0);
        end
        reset = 1'b1;
        do_access(0, 1'b0, 1'b0, 8'd30, 16'h0000, l, rd);
        chk("post_abort_latency", l, 32'd3);
        chk("post_abort_data", {16'd0, rd}, 32'h5A5A);

        // 6: latency-3 instance, top address
        do_access(1, 1'b0, 1'b1, 8'hFF, 16'hFFFF, l, rd);
        chk("l3_wr_latency", l, 32'd2);
        do_access(1, 1'b0, 1'b0, 8'hFF, 16'h0000, l, rd);
        chk("l3_rd_latency", l, 32'd5);
        chk("l3_rd_data", {16'd0, rd}, 32'h0000FFFF);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
